fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the fetch PC, issues single-outstanding requests to instruction memory, and buffers returned words with their PC+4 in a 2-entry queue. Its head entry drives the instruction and PC+4 inputs of the IF/ID pipeline register. It absorbs hazard-unit stalls and decode-stage branch/jump redirects without losing or duplicating instructions.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage of the five-stage MIPS pipeline.
//               Owns the fetch PC and issues one outstanding request at a
//               time to instruction memory. Returned words are buffered with
//               their PC+4 in a small prefetch queue. The queue head feeds
//               the IF/ID pipeline register. Hazard stalls and decode-stage
//               redirects are absorbed without losing or duplicating
//               instructions.
// Ports       : clk, rst_n          - clock, async active-low reset
//               stall_f             - hold the head entry (no pop)
//               redirect/redirect_pc- taken branch/jump from decode
//               imem_req/imem_addr  - fetch request, held until imem_ack
//               imem_ack/imem_rdata - memory completion and instruction word
//               instr_f/pc_plus4_f  - head instruction and its PC+4 (0 if idle)
//               valid_f             - head entry is a live instruction
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          DEPTH    = 2              // 2 or 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_f,
   output logic [31:0] pc_plus4_f,
   output logic        valid_f
);

   localparam int              c_PTR_W   = $clog2(DEPTH);
   localparam int              c_CNT_W   = $clog2(DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DROP = 1'b1     // waiting out an in-flight request made stale by a redirect
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [31:0]          hold_q, hold_d;
   logic [c_CNT_W-1:0]   count_q, count_d;
   logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [31:0]          instr_mem_q [DEPTH];
   logic [31:0]          pcp4_mem_q  [DEPTH];

   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;

   // ------------------------------------------------------------------------
   // Request side. A full queue blocks requests even if a pop is happening
   // this cycle, which keeps the request free of any stall_f dependency.
   // ------------------------------------------------------------------------
   assign w_full    = (count_q == c_DEPTH_CNT);
   assign imem_req  = rst_n && ((state_q == ST_DROP) || !w_full);
   assign imem_addr = (state_q == ST_DROP) ? hold_q : pc_q;

   // ------------------------------------------------------------------------
   // Head side. A redirect squashes the head so IF/ID captures a nop.
   // ------------------------------------------------------------------------
   assign valid_f    = (count_q != '0) && !redirect;
   assign instr_f    = valid_f ? instr_mem_q[rd_ptr_q] : 32'd0;
   assign pc_plus4_f = valid_f ? pcp4_mem_q[rd_ptr_q]  : 32'd0;

   assign w_push = (state_q == ST_RUN) && imem_req && imem_ack && !redirect;
   assign w_pop  = valid_f && !stall_f;

   // ------------------------------------------------------------------------
   // Next-state: FSM, fetch PC and held address
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      case (state_q)
         ST_RUN: begin
            if (redirect) begin
               pc_d = redirect_pc;
               // Request already on the bus must complete at its own address
               if (imem_req && !imem_ack) begin
                  hold_d  = pc_q;
                  state_d = ST_DROP;
               end
            end else if (w_push) begin
               pc_d = pc_q + 32'd4;
            end
         end
         ST_DROP: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (imem_ack) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state: queue occupancy and pointers
   // ------------------------------------------------------------------------
   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
         end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_ONE;
         end
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         hold_q   <= 32'd0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         hold_q   <= hold_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Queue storage needs no reset: entries are only visible when counted.
   always_ff @(posedge clk) begin
      if (w_push) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pcp4_mem_q[wr_ptr_q]  <= pc_q + 32'd4;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A memory model
//               returns the address as data with programmable ack latency;
//               the expected instruction stream is queued as stimulus is
//               applied and compared whenever the head is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_f;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_f;
   logic [31:0] pc_plus4_f;
   logic        valid_f;

   int          checks = 0;
   int          errors = 0;
   int          lat    = 0;
   int          wait_cnt = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (32'h0040_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_f     (stall_f),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_f     (instr_f),
      .pc_plus4_f  (pc_plus4_f),
      .valid_f     (valid_f)
   );

   // Memory model: ack after `lat` cycles of a held request, data = address
   assign imem_ack   = imem_req && (wait_cnt == lat);
   assign imem_rdata = imem_addr;
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare the head against the scoreboard if it is consumed this cycle,
   // then advance to 1 time unit after the next rising edge.
   task automatic cyc();
      logic [31:0] a;
      #1;
      if (valid_f && !stall_f) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=pop(%h) expected=no_pop", instr_f);
         end
         if (sb.size() != 0) begin
            a = sb.pop_front();
            chk("head_instr", instr_f, a);
            chk("head_pc4", pc_plus4_f, a + 32'd4);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stall_f = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; lat = 0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, valid_f},  32'd0);
      chk("rst_instr", instr_f,           32'd0);
      chk("rst_pc4",   pc_plus4_f,        32'd0);
      chk("rst_addr",  imem_addr,         32'h0040_0000);

      // Release: first word pushed at the next edge
      rst_n = 1'b1;
      #1;
      chk("rel_valid", {31'd0, valid_f},  32'd0);
      chk("rel_req",   {31'd0, imem_req}, 32'd1);
      chk("rel_addr",  imem_addr,         32'h0040_0000);
      sb.push_back(32'h0040_0000);
      sb.push_back(32'h0040_0004);
      cyc();
      chk("first_valid", {31'd0, valid_f}, 32'd1);
      cyc();
      cyc();

      // Stall 5 cycles: queue fills to 2, requests stop, head holds 0x08
      stall_f = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("stall_count", 32'(dut.count_q), 32'd2);
         chk("stall_req",   {31'd0, imem_req}, 32'd0);
         chk("stall_head",  instr_f,           32'h0040_0008);
         cyc();
      end
      stall_f = 1'b0;
      sb.push_back(32'h0040_0008);
      sb.push_back(32'h0040_000C);
      sb.push_back(32'h0040_0010);
      cyc(); cyc(); cyc();

      // Fill the queue to 2 entries, then redirect
      stall_f = 1'b1;
      cyc();
      stall_f = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0040_0100;
      #1;
      chk("redir_full",  32'(dut.count_q), 32'd2);
      chk("redir_valid", {31'd0, valid_f}, 32'd0);
      chk("redir_instr", instr_f,          32'd0);
      chk("redir_pc4",   pc_plus4_f,       32'd0);
      cyc();
      redirect = 1'b0;
      chk("redir_flush", 32'(dut.count_q), 32'd0);
      chk("redir_addr",  imem_addr,        32'h0040_0100);
      sb.push_back(32'h0040_0100);
      sb.push_back(32'h0040_0104);
      cyc();
      chk("tgt_valid", {31'd0, valid_f}, 32'd1);
      chk("tgt_instr", instr_f,          32'h0040_0100);
      cyc(); cyc();

      // Redirect with a zero-wait request in the same cycle: word discarded
      stall_f = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0040_0008;
      cyc();
      stall_f = 1'b0;
      redirect = 1'b0;
      lat = 3;
      chk("lat_addr", imem_addr, 32'h0040_0008);
      sb.push_back(32'h0040_0008);
      cyc(); cyc(); cyc(); cyc();
      chk("lat_valid", {31'd0, valid_f}, 32'd1);
      chk("lat_next_addr", imem_addr, 32'h0040_000C);
      cyc();

      // Redirect one cycle into the request for 0x0C: address held until ack
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      cyc();
      redirect = 1'b0;
      chk("drop_addr1", imem_addr,         32'h0040_000C);
      chk("drop_req",   {31'd0, imem_req}, 32'd1);
      chk("drop_valid", {31'd0, valid_f},  32'd0);
      cyc();
      chk("drop_addr2", imem_addr, 32'h0040_000C);
      cyc();
      chk("drop_new_addr", imem_addr,        32'h0000_0200);
      chk("drop_valid2",   {31'd0, valid_f}, 32'd0);
      sb.push_back(32'h0000_0200);
      cyc(); cyc(); cyc(); cyc();
      lat = 0;
      chk("drop_tgt_valid", {31'd0, valid_f}, 32'd1);
      cyc();

      // Redirect to the top of the address space: PC+4 wraps to 0
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cyc();
      redirect = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      sb.push_back(32'hFFFF_FFFC);
      sb.push_back(32'h0000_0000);
      cyc();
      chk("wrap_pc4",  pc_plus4_f, 32'h0000_0000);
      chk("wrap_next", imem_addr,  32'h0000_0000);
      cyc();
      lat = 3;
      cyc();

      // Reset while a request is pending
      chk("pend_req", {31'd0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req",   {31'd0, imem_req}, 32'd0);
      chk("async_valid", {31'd0, valid_f},  32'd0);
      chk("async_count", 32'(dut.count_q),  32'd0);
      chk("async_addr",  imem_addr,         32'h0040_0000);
      @(posedge clk);
      #1;
      lat = 0;
      rst_n = 1'b1;
      #1;
      chk("restart_addr", imem_addr, 32'h0040_0000);
      sb.push_back(32'h0040_0000);
      cyc();
      chk("restart_valid", {31'd0, valid_f}, 32'd1);
      cyc();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
